// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_defs (package)
// Description : Shared definitions for the EX-stage multiply/divide unit:
//               operation encodings, FSM states and default latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package md_defs;

    // Operation select carried on MDOp.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    // Unit state: IDLE accepts new work, BUSY counts down the fixed latency.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // True for the four operations that occupy the unit for several cycles.
    function automatic logic is_md_start_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : Pipeline-side bundle of the multiply/divide unit: issue
//               controls and operands in, busy flag and HI/LO reads out.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;

    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HL_busy;
    logic [31:0] HL_out;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline / hazard-control side.
    modport master (
        output Start, MDOp, A, B,
        input  HL_busy, HL_out, HI, LO
    );

    // Multiply/divide unit side.
    modport slave (
        input  Start, MDOp, A, B,
        output HL_busy, HL_out, HI, LO
    );

endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : EX-stage multiply/divide unit owning HI/LO. The result is
//               computed combinationally at Start, parked in shadow
//               registers and committed after a fixed latency so that a
//               later iterative divider can slot in with identical timing.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  wire logic clk,
    input  wire logic reset,
    md_unit_if.slave  md
);

    localparam int unsigned c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned c_cnt_w      = $clog2(c_max_cycles) + 1;

    md_state_e            r_state;
    logic                 r_busy;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_sh_hi;
    logic [31:0]          r_sh_lo;
    logic                 r_sh_valid;

    md_op_e               w_op;
    logic                 w_start;
    logic                 w_is_div;
    logic                 w_div_zero;
    logic [63:0]          w_a_sext;
    logic [63:0]          w_b_sext;
    logic [63:0]          w_prod_s;
    logic [63:0]          w_prod_u;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [31:0]          w_a_mag;
    logic [31:0]          w_b_mag;
    logic [31:0]          w_b_div;
    logic [31:0]          w_q_mag;
    logic [31:0]          w_r_mag;
    logic [31:0]          w_q;
    logic [31:0]          w_r;
    logic [63:0]          w_result;
    logic [31:0]          w_hl_out;

    assign w_op       = md_op_e'(md.MDOp);
    assign w_start    = md.Start && is_md_start_op(md.MDOp) && (r_state == ST_IDLE);
    assign w_is_div   = (w_op == MD_DIV) || (w_op == MD_DIVU);
    assign w_div_zero = (md.B == 32'd0);

    // The low 64 bits of a product of sign-extended operands equal the
    // signed 64-bit product, so both multiplies share unsigned arithmetic.
    assign w_a_sext = {{32{md.A[31]}}, md.A};
    assign w_b_sext = {{32{md.B[31]}}, md.B};
    assign w_prod_s = w_a_sext * w_b_sext;
    assign w_prod_u = {32'd0, md.A} * {32'd0, md.B};

    // Signed divide is done on magnitudes; this sidesteps the
    // 0x80000000 / -1 overflow, whose magnitude quotient 0x80000000 already
    // has the wrapped value the ISA expects.
    assign w_a_neg = (w_op == MD_DIV) && md.A[31];
    assign w_b_neg = (w_op == MD_DIV) && md.B[31];
    assign w_a_mag = w_a_neg ? (~md.A + 32'd1) : md.A;
    assign w_b_mag = w_b_neg ? (~md.B + 32'd1) : md.B;
    // A zero divisor is replaced so the datapath never divides by zero;
    // that result is discarded at commit anyway.
    assign w_b_div = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_b_div;
    assign w_r_mag = w_a_mag % w_b_div;
    assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Select the {HI, LO} pair the current operation would produce.
    always_comb begin
        w_result = 64'd0;
        case (w_op)
            MD_MULT:          w_result = w_prod_s;
            MD_MULTU:         w_result = w_prod_u;
            MD_DIV, MD_DIVU:  w_result = {w_r, w_q};
            default:          w_result = 64'd0;
        endcase
    end

    // Issue/commit FSM with HI/LO, shadow result and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_sh_hi    <= 32'd0;
            r_sh_lo    <= 32'd0;
            r_sh_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sh_hi    <= w_result[63:32];
                        r_sh_lo    <= w_result[31:0];
                        r_sh_valid <= !(w_is_div && w_div_zero);
                        r_cnt      <= w_is_div ? c_cnt_w'(DIV_CYCLES) : c_cnt_w'(MULT_CYCLES);
                        r_busy     <= 1'b1;
                        r_state    <= ST_BUSY;
                    end else if (!md.Start) begin
                        if (w_op == MD_MTHI) begin
                            r_hi <= md.A;
                        end
                        if (w_op == MD_MTLO) begin
                            r_lo <= md.A;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        if (r_sh_valid) begin
                            r_hi <= r_sh_hi;
                            r_lo <= r_sh_lo;
                        end
                        r_sh_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // mfhi/mflo read the architectural registers directly, no shadow bypass.
    always_comb begin
        w_hl_out = 32'd0;
        case (w_op)
            MD_MFHI: w_hl_out = r_hi;
            MD_MFLO: w_hl_out = r_lo;
            default: w_hl_out = 32'd0;
        endcase
    end

    assign md.HL_busy = md.Start | r_busy;
    assign md.HL_out  = w_hl_out;
    assign md.HI      = r_hi;
    assign md.LO      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit with a result
//               scoreboard fed at issue and drained at commit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic clk;
    logic reset;

    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES (N_MULT),
        .DIV_CYCLES  (N_DIV)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    // Issue one multi-cycle op at the current cycle, check the busy window,
    // then the committed HI/LO. Optionally injects an illegal op at busy
    // cycle inj_k. With chain set, returns mid-cycle in the commit-visible
    // cycle so the next op can issue there.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, input logic [3:0] inj_op, input logic inj_start,
                          input bit chain);
        int          n;
        logic [63:0] e;
        n = (op >= 4'd3) ? N_DIV : N_MULT;
        e = model(op, a, b, m_hi, m_lo);
        {m_hi, m_lo} = e;
        sb_q.push_back(e);
        chk("busy_pre", bus.HL_busy, 1'b0);
        bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        #3 chk("busy_T", bus.HL_busy, 1'b1);
        cyc();
        bus.Start = 1'b0; bus.MDOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        for (int k = 1; k <= n; k++) begin
            if (k == inj_k) begin
                bus.Start = inj_start; bus.MDOp = inj_op;
                bus.A = 32'hDEAD_BEEF; bus.B = 32'd3;
            end
            #3 chk($sformatf("busy_T+%0d", k), bus.HL_busy, 1'b1);
            cyc();
            bus.Start = 1'b0; bus.MDOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        end
        #3 chk("busy_end", bus.HL_busy, 1'b0);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk("commit_hi", bus.HI, e[63:32]);
            chk("commit_lo", bus.LO, e[31:0]);
            if (!chain) begin
                bus.MDOp = 4'd7;
                #1 chk("mfhi", bus.HL_out, e[63:32]);
                bus.MDOp = 4'd8;
                #1 chk("mflo", bus.HL_out, e[31:0]);
                bus.MDOp = 4'd0;
                cyc();
            end
        end
    endtask

    // Single-cycle move-to; checks no busy and the read-back next cycle.
    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        bus.MDOp = op; bus.A = a;
        #3 chk("mt_busy", bus.HL_busy, 1'b0);
        if (op == 4'd5) m_hi = a; else m_lo = a;
        cyc();
        bus.MDOp = 4'd7; bus.A = 32'd0;
        #3 chk("mt_mfhi", bus.HL_out, m_hi);
        bus.MDOp = 4'd8;
        #1 chk("mt_mflo", bus.HL_out, m_lo);
        chk("mt_busy_after", bus.HL_busy, 1'b0);
        bus.MDOp = 4'd0;
        cyc();
    endtask

    initial begin
        total = 0; bad = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1;
        bus.Start = 1'b0; bus.MDOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        repeat (2) cyc();
        reset = 1'b0;
        #3;
        chk("rst_busy", bus.HL_busy, 1'b0);
        chk("rst_out",  bus.HL_out,  32'd0);
        chk("rst_hi",   bus.HI,      32'd0);
        chk("rst_lo",   bus.LO,      32'd0);
        cyc();

        // Signed and unsigned multiply.
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 4'd0, 1'b0, 1'b0);
        chk("t1_hi_const", bus.HI, 32'hFFFF_FFFF);
        chk("t1_lo_const", bus.LO, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 0, 4'd0, 1'b0, 1'b0);
        chk("t2_hi_const", bus.HI, 32'd1);

        // Signed divide, then divu by zero with an illegal mtlo while busy.
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 4'd0, 1'b0, 1'b0);
        chk("t3_lo_const", bus.LO, 32'hFFFF_FFFD);
        chk("t3_hi_const", bus.HI, 32'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd0, 3, 4'd6, 1'b0, 1'b0);

        // Move-to operations.
        move_to(4'd5, 32'h1234_5678);
        move_to(4'd6, 32'hCAFE_0001);

        // Overflow divide and signed divide by zero.
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'd0, 1'b0, 1'b0);
        chk("ovf_lo_const", bus.LO, 32'h8000_0000);
        chk("ovf_hi_const", bus.HI, 32'd0);
        run_op(4'd3, 32'd100, 32'd0, 5, 4'd5, 1'b0, 1'b0);

        // Reset mid-divide aborts the operation.
        bus.Start = 1'b1; bus.MDOp = 4'd3; bus.A = 32'd1000; bus.B = 32'd7;
        cyc();
        bus.Start = 1'b0; bus.MDOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        #3;
        chk("rst_mid_busy", bus.HL_busy, 1'b0);
        chk("rst_mid_hi",   bus.HI,      32'd0);
        chk("rst_mid_lo",   bus.LO,      32'd0);
        repeat (7) cyc();
        #3;
        chk("rst_nocommit_hi",   bus.HI,      32'd0);
        chk("rst_nocommit_lo",   bus.LO,      32'd0);
        chk("rst_nocommit_busy", bus.HL_busy, 1'b0);
        cyc();

        // Back-to-back: div issues in the cycle the mult result appears;
        // a second Start during the div is ignored.
        run_op(4'd1, 32'd123456, 32'hFFFF_FF00, 0, 4'd0, 1'b0, 1'b1);
        run_op(4'd3, 32'hFFFF_0000, 32'd7, 4, 4'd1, 1'b1, 1'b0);

        // A few random operations.
        for (int i = 0; i < 6; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 20));
            run_op(op, a, b, 0, 4'd0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
